// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/delay-slot sequencer for the five-stage core.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallreq_if_i,
    input  logic            stallreq_id_i,
    input  logic            stallreq_ex_i,
    input  logic            stallreq_mem_i,
    input  logic            ex_mc_start_i,
    input  logic [4:0]      ex_mc_len_i,
    input  logic            excp_i,
    input  logic            branch_flag_i,
    input  logic            next_in_delayslot_i,
    output logic [5:0]      stall_o,
    output logic            flush_o,
    output logic [PC_W-1:0] new_pc_o,
    output logic            ex_mc_done_o,
    output logic            now_in_delayslot_o,
    output logic [31:0]     stall_cnt_o,
    output logic [31:0]     flush_cnt_o
);

    // state  | meaning
    // RUN    | normal issue, may accept a multi-cycle EX op
    // MULTI  | multi-cycle EX op in flight, counter tracks remaining cycles
    // FREEZE | exception seen, whole pipe held, mc op aborted
    // FLUSH  | one-cycle flush with redirect to the exception vector
    typedef enum logic [1:0] {RUN, MULTI, FREEZE, FLUSH} state_t;

    state_t     state_q, state_d;
    logic [4:0] mc_cnt_q, mc_cnt_d;
    logic       mc_req;
    logic       ds_q, ds_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= RUN;
            mc_cnt_q <= 5'd0;
            ds_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
            ds_q     <= ds_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        mc_req       = 1'b0;
        ex_mc_done_o = 1'b0;
        flush_o      = 1'b0;
        new_pc_o     = '0;
        case (state_q)
            RUN: begin
                if (excp_i) begin
                    state_d = FREEZE;
                end else if (ex_mc_start_i && (ex_mc_len_i >= 5'd2)) begin
                    state_d  = MULTI;
                    mc_cnt_d = ex_mc_len_i - 5'd1;
                    mc_req   = 1'b1;
                end
            end
            MULTI: begin
                if (mc_cnt_q > 5'd1) begin
                    mc_req   = 1'b1;
                    mc_cnt_d = mc_cnt_q - 5'd1;
                end else begin
                    ex_mc_done_o = 1'b1;
                    mc_cnt_d     = 5'd0;
                    state_d      = RUN;
                end
                if (excp_i) begin
                    state_d  = FREEZE;
                    mc_cnt_d = 5'd0;
                end
            end
            FREEZE: begin
                state_d  = FLUSH;
                mc_cnt_d = 5'd0;
            end
            FLUSH: begin
                state_d  = RUN;
                flush_o  = 1'b1;
                new_pc_o = EXC_VECTOR;
            end
            default: state_d = RUN;
        endcase
    end

    // Highest requesting stage wins; FREEZE and FLUSH override requests.
    always_comb begin
        stall_o = 6'b000000;
        if (state_q == FREEZE)              stall_o = 6'b111111;
        else if (state_q == FLUSH)          stall_o = 6'b000000;
        else if (stallreq_mem_i)            stall_o = 6'b011111;
        else if (stallreq_ex_i || mc_req)   stall_o = 6'b001111;
        else if (stallreq_id_i)             stall_o = 6'b000111;
        else if (stallreq_if_i)             stall_o = 6'b000011;
    end

    always_comb begin
        ds_d = ds_q;
        if (state_q == FLUSH)  ds_d = 1'b0;
        else if (!stall_o[2])  ds_d = branch_flag_i & next_in_delayslot_i;
    end

    assign now_in_delayslot_o = ds_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if ((stall_o != 6'd0) && (stall_cnt_q != 32'hFFFF_FFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if ((state_q == FLUSH) && (flush_cnt_q != 32'hFFFF_FFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    assign stall_cnt_o = 32'd0;
    assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: per-cycle expectations queued with stimulus,
// compared against sampled outputs at the end of each scenario.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic        ex_mc_start_i;
    logic [4:0]  ex_mc_len_i;
    logic        excp_i, branch_flag_i, next_in_delayslot_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        ex_mc_done_o, now_in_delayslot_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        done;
        logic        ds;
        logic        ck;
    } smp_t;

    smp_t exp_q[$];
    smp_t obs_q[$];

    pipe_ctrl #(.PC_W(32), .EXC_VECTOR(32'h0000_0020)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if_i(stallreq_if_i), .stallreq_id_i(stallreq_id_i),
        .stallreq_ex_i(stallreq_ex_i), .stallreq_mem_i(stallreq_mem_i),
        .ex_mc_start_i(ex_mc_start_i), .ex_mc_len_i(ex_mc_len_i),
        .excp_i(excp_i), .branch_flag_i(branch_flag_i),
        .next_in_delayslot_i(next_in_delayslot_i),
        .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o),
        .ex_mc_done_o(ex_mc_done_o), .now_in_delayslot_o(now_in_delayslot_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; req = {mem, ex, id, if}, bd = {branch, next_in_ds}.
    // Starts 1 time unit after a rising edge, samples just before the next one.
    task automatic cyc(input logic r, input logic [3:0] req, input logic st,
                       input logic [4:0] len, input logic ex, input logic [1:0] bd,
                       input logic [5:0] es, input logic ef, input logic ed,
                       input logic eds, input logic ck = 1'b1);
        smp_t e, o;
        rst = r;
        {stallreq_mem_i, stallreq_ex_i, stallreq_id_i, stallreq_if_i} = req;
        ex_mc_start_i = st;
        ex_mc_len_i   = len;
        excp_i        = ex;
        {branch_flag_i, next_in_delayslot_i} = bd;
        e.stall = es; e.flush = ef; e.pc = ef ? 32'h0000_0020 : 32'h0;
        e.done = ed; e.ds = eds; e.ck = ck;
        exp_q.push_back(e);
        #7;
        o.stall = stall_o; o.flush = flush_o; o.pc = new_pc_o;
        o.done = ex_mc_done_o; o.ds = now_in_delayslot_o; o.ck = 1'b1;
        obs_q.push_back(o);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        smp_t e, o;
        int k = 0;
        cyc(1, 4'b0000, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0, 2'b00, 6'h00, 0, 0, 0);
        n_run++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counters got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if ({o.stall, o.flush, o.pc, o.done, o.ds} !== {e.stall, e.flush, e.pc, e.done, e.ds}) begin
                n_fail++;
                $display("FAIL reset cyc%0d got st=%b fl=%b pc=%h dn=%b ds=%b exp st=%b fl=%b pc=%h dn=%b ds=%b",
                         k, o.stall, o.flush, o.pc, o.done, o.ds, e.stall, e.flush, e.pc, e.done, e.ds);
            end
            k++;
        end
    endtask

    task automatic test_stall_merge();
        smp_t e, o;
        int k = 0;
        cyc(0, 4'b1010, 0, 0, 0, 2'b00, 6'b011111, 0, 0, 0);
        cyc(0, 4'b0010, 0, 0, 0, 2'b00, 6'b000111, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 0, 2'b00, 6'b000011, 0, 0, 0);
        cyc(0, 4'b0100, 0, 0, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0101, 0, 0, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b1111, 0, 0, 0, 2'b00, 6'b011111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0, 2'b00, 6'b000000, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if ({o.stall, o.flush, o.pc, o.done, o.ds} !== {e.stall, e.flush, e.pc, e.done, e.ds}) begin
                n_fail++;
                $display("FAIL stall_merge cyc%0d got st=%b fl=%b pc=%h dn=%b ds=%b exp st=%b fl=%b pc=%h dn=%b ds=%b",
                         k, o.stall, o.flush, o.pc, o.done, o.ds, e.stall, e.flush, e.pc, e.done, e.ds);
            end
            k++;
        end
    endtask

    task automatic test_multi();
        smp_t e, o;
        int k = 0;
        // len=4: stalled 3 cycles, done on the 4th
        cyc(0, 4'b0000, 1, 5'd4, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 1, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        // len=1 and len=0 behave as single-cycle ops
        cyc(0, 4'b0000, 1, 5'd1, 0, 2'b00, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 1, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        // len=2: one stalled cycle, then done
        cyc(0, 4'b0000, 1, 5'd2, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 1, 0);
        // MEM stall mid-op does not delay completion; a start inside MULTI is ignored
        cyc(0, 4'b0000, 1, 5'd4, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b1000, 1, 5'd9, 0, 2'b00, 6'b011111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0001, 0, 5'd0, 0, 2'b00, 6'b000011, 0, 1, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if ({o.stall, o.flush, o.pc, o.done, o.ds} !== {e.stall, e.flush, e.pc, e.done, e.ds}) begin
                n_fail++;
                $display("FAIL multi cyc%0d got st=%b fl=%b pc=%h dn=%b ds=%b exp st=%b fl=%b pc=%h dn=%b ds=%b",
                         k, o.stall, o.flush, o.pc, o.done, o.ds, e.stall, e.flush, e.pc, e.done, e.ds);
            end
            k++;
        end
    endtask

    task automatic test_excp();
        smp_t e, o;
        int k = 0;
        // exception in the 4th cycle of a len=8 op
        cyc(0, 4'b0000, 1, 5'd8, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 1, 2'b00, 6'b001111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b111111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 1, 0, 0);
        for (int i = 0; i < 8; i++)
            cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        // exception wins over a simultaneous start; requests masked while flushing
        cyc(0, 4'b0000, 1, 5'd4, 1, 2'b00, 6'b000000, 0, 0, 0, 1'b0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b111111, 0, 0, 0);
        cyc(0, 4'b1000, 0, 5'd0, 0, 2'b00, 6'b000000, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if ({(e.ck ? o.stall : 6'h0), o.flush, o.pc, o.done, o.ds} !==
                {(e.ck ? e.stall : 6'h0), e.flush, e.pc, e.done, e.ds}) begin
                n_fail++;
                $display("FAIL excp cyc%0d got st=%b fl=%b pc=%h dn=%b ds=%b exp st=%b fl=%b pc=%h dn=%b ds=%b",
                         k, o.stall, o.flush, o.pc, o.done, o.ds, e.stall, e.flush, e.pc, e.done, e.ds);
            end
            k++;
        end
    endtask

    task automatic test_delayslot();
        smp_t e, o;
        int k = 0;
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b11, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        // ID stalled when the branch is seen: flag not set
        cyc(0, 4'b0010, 0, 5'd0, 0, 2'b11, 6'b000111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        // flag holds while ID is stalled, IF-only stall does not hold it
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b11, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0010, 0, 5'd0, 0, 2'b00, 6'b000111, 0, 0, 1);
        cyc(0, 4'b0001, 0, 5'd0, 0, 2'b00, 6'b000011, 0, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b10, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b01, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        // FREEZE holds the flag, FLUSH clears it even with branch inputs high
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b11, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 1, 2'b11, 6'b000000, 0, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b11, 6'b111111, 0, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 1, 2'b11, 6'b000000, 1, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b11, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if ({o.stall, o.flush, o.pc, o.done, o.ds} !== {e.stall, e.flush, e.pc, e.done, e.ds}) begin
                n_fail++;
                $display("FAIL delayslot cyc%0d got st=%b fl=%b pc=%h dn=%b ds=%b exp st=%b fl=%b pc=%h dn=%b ds=%b",
                         k, o.stall, o.flush, o.pc, o.done, o.ds, e.stall, e.flush, e.pc, e.done, e.ds);
            end
            k++;
        end
    endtask

    task automatic test_rst_multi();
        smp_t e, o;
        int k = 0;
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b11, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 1, 5'd8, 0, 2'b00, 6'b001111, 0, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 1);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 1);
        cyc(1, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b001111, 0, 0, 1);
        for (int i = 0; i < 8; i++)
            cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_run++;
            if ({o.stall, o.flush, o.pc, o.done, o.ds} !== {e.stall, e.flush, e.pc, e.done, e.ds}) begin
                n_fail++;
                $display("FAIL rst_multi cyc%0d got st=%b fl=%b pc=%h dn=%b ds=%b exp st=%b fl=%b pc=%h dn=%b ds=%b",
                         k, o.stall, o.flush, o.pc, o.done, o.ds, e.stall, e.flush, e.pc, e.done, e.ds);
            end
            k++;
        end
    endtask

    task automatic test_perf();
        logic [31:0] exp_s, exp_f;
        cyc(1, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
        n_run++;
        if (stall_cnt_o !== 32'd0 || flush_cnt_o !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_clear got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o);
        end
        for (int i = 0; i < 3; i++)
            cyc(0, 4'b0010, 0, 5'd0, 0, 2'b00, 6'b000111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 1, 2'b00, 6'b000000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b111111, 0, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 1, 0, 0);
        cyc(0, 4'b0000, 0, 5'd0, 0, 2'b00, 6'b000000, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
        exp_s = 32'd4; exp_f = 32'd1;
`else
        exp_s = 32'd0; exp_f = 32'd0;
`endif
        n_run++;
        if (stall_cnt_o !== exp_s) begin
            n_fail++;
            $display("FAIL perf_stall_cnt got %0d exp %0d", stall_cnt_o, exp_s);
        end
        n_run++;
        if (flush_cnt_o !== exp_f) begin
            n_fail++;
            $display("FAIL perf_flush_cnt got %0d exp %0d", flush_cnt_o, exp_f);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        {stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i} = 4'b0;
        ex_mc_start_i = 1'b0; ex_mc_len_i = 5'd0; excp_i = 1'b0;
        branch_flag_i = 1'b0; next_in_delayslot_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_stall_merge();
        test_multi();
        test_excp();
        test_delayslot();
        test_rst_multi();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline stall, flush and delay-slot sequencer for the five-stage MIPS core. It merges stall requests from IF/ID/EX/MEM into a per-stage stall vector. It sequences multi-cycle EX operations and turns a MEM-stage exception into a freeze-then-flush sequence with a redirect PC. It also owns the branch delay-slot flag that is fed back into the decode stage.

## Interface
Parameters:
- `PC_W`, 32, width of `new_pc_o`
- `EXC_VECTOR`, 32'h0000_0020, redirect address driven during flush

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `stallreq_if_i`  in  1  IF stage stall request
- `stallreq_id_i`  in  1  ID stage stall request, e.g. load-use
- `stallreq_ex_i`  in  1  EX stage stall request
- `stallreq_mem_i`  in  1  MEM stage stall request
- `ex_mc_start_i`  in  1  EX begins a multi-cycle operation
- `ex_mc_len_i`  in  5  total cycles of that operation
- `excp_i`  in  1  MEM-stage exception detected
- `branch_flag_i`  in  1  ID resolved a taken jump/branch
- `next_in_delayslot_i`  in  1  ID marks the following instruction as a delay slot
- `stall_o`  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold
- `flush_o`  out  1  clear all pipeline registers
- `new_pc_o`  out  PC_W  fetch redirect, valid when `flush_o`=1
- `ex_mc_done_o`  out  1  one-cycle pulse on the final cycle of a multi-cycle op
- `now_in_delayslot_o`  out  1  instruction now in ID is a delay slot
- `stall_cnt_o`  out  32  stalled-cycle counter (see Configuration)
- `flush_cnt_o`  out  32  flush counter (see Configuration)

## Operation
- States: RUN, MULTI, FREEZE, FLUSH. Reset state is RUN.
- Reset values: `stall_o`=0, `flush_o`=0, `new_pc_o`=0, `ex_mc_done_o`=0, `now_in_delayslot_o`=0, counters 0, mc counter 0.
- Stall vector is combinational. The highest requesting stage wins:
  - MEM: 6'b011111
  - EX or MULTI-internal request: 6'b001111
  - ID: 6'b000111
  - IF: 6'b000011
  - none: 0
- RUN→MULTI: when `ex_mc_start_i` and `ex_mc_len_i`≥2, load counter = len−1.
  - If len<2, the op is treated as single-cycle: no state change, no done pulse.
  - `ex_mc_start_i` is ignored outside RUN.
- MULTI: the internal EX request is active while counter>1. The counter decrements every cycle, including cycles where MEM stalls.
- MULTI→RUN: when the counter reaches 1. In that cycle `ex_mc_done_o`=1 and the internal request is dropped.
- Any state→FREEZE on `excp_i`. In FREEZE, `stall_o`=6'b111111 and the mc counter is cleared (abort).
  - `excp_i` has priority over every other input, including a simultaneous `ex_mc_start_i`.
- FREEZE→FLUSH unconditionally. In FLUSH:
  - `flush_o`=1, `new_pc_o`=EXC_VECTOR, `stall_o`=0
  - the delay-slot flag is cleared
  - `excp_i` is ignored in this state
- FLUSH→RUN unconditionally. Outside FLUSH, `new_pc_o`=0.
- Delay slot flag `ds_q`:
  - When `stall_o[2]`=0 and not FLUSH: `ds_q` ← `branch_flag_i & next_in_delayslot_i`.
  - It holds while ID is stalled.
  - `now_in_delayslot_o`=`ds_q`.
- Synchronous reset asserted in any state, including mid-MULTI or FREEZE: next edge returns to RUN with all reset values.

## Timing
- Stall requests reach `stall_o` in the same cycle; there is no latency.
- Multi-cycle op, start in cycle N with len L:
  - `stall_o`=6'b001111 in cycles N..N+L−2
  - `ex_mc_done_o` high in cycle N+L−1
  - `stall_o` is 0 in cycle N+L−1 unless another request is active
- Exception sampled in cycle N:
  - cycle N+1: FREEZE
  - cycle N+2: FLUSH pulse, exactly one cycle
  - cycle N+3: RUN
- Delay-slot flag: the instruction decoded in cycle N+1 sees the branch/next-in-delayslot sampled in cycle N, provided ID was not stalled in cycle N.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt_o` increments every cycle `stall_o`≠0.
  - `flush_cnt_o` increments every FLUSH cycle.
  - Both saturate at 32'hFFFF_FFFF and clear on reset.
- `PIPE_CTRL_PERF_EN` not defined: both outputs are constant 0 and no counter flops exist.

## Test plan
- Set `stallreq_id_i`=1 and `stallreq_mem_i`=1 together → `stall_o`=6'b011111. Then `stallreq_id_i` alone → 6'b000111.
- `ex_mc_start_i` with len=4 at cycle 10 → `stall_o`=6'b001111 in cycles 10–12, `ex_mc_done_o`=1 in cycle 13, `stall_o`=0 in cycle 13. Len=1 → no stall and no done pulse.
- `excp_i` in cycle 3 of a len=8 op → FREEZE with `stall_o`=6'b111111 next cycle, then `flush_o`=1 with `new_pc_o`=32'h20, then RUN with no `ex_mc_done_o` ever.
- `branch_flag_i`=`next_in_delayslot_i`=1 in cycle 5 → `now_in_delayslot_o`=1 in cycle 6, 0 in cycle 7. The same stimulus with ID stalled in cycle 5 → flag stays 0 in cycle 6.
- Assert `rst` during MULTI with the counter at 5 → next cycle `stall_o`=0, `ex_mc_done_o`=0, and the delay-slot flag is 0.
- With `PIPE_CTRL_PERF_EN`: 3 stalled cycles plus 1 exception → `stall_cnt_o`=4 (3 + FREEZE) and `flush_cnt_o`=1. Without the macro, both are 0.
